// File: rtl/errors_scheduler.sv
// Round-robin error report sequencer for a bank of sticky error lockers.
// Reports each newly set error bit once per clear epoch and drives the lockers' clear pulse.
module errors_scheduler #(
    parameter int unsigned SOURCES      = 4,
    parameter int unsigned BITS         = 8,
    parameter int unsigned CLEAR_CYCLES = 4,
    localparam int unsigned IDX_W       = $clog2(SOURCES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SOURCES*BITS-1:0] i_errors,
    input  logic                    i_clear,
    output logic                    o_clear,
    output logic                    o_rpt_valid,
    input  logic                    i_rpt_ready,
    output logic [IDX_W-1:0]        o_rpt_src,
    output logic [BITS-1:0]         o_rpt_bits,
    output logic                    o_rpt_first,
    output logic                    o_first_valid,
    output logic [IDX_W-1:0]        o_first_src
);

    localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [IDX_W-1:0] RR_RST = IDX_W'(SOURCES - 1);

    typedef enum logic [1:0] {StIdle, StReport, StClear} state_e;

    state_e                  state_q, state_d;
    logic [SOURCES*BITS-1:0] seen_q, seen_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic                    clear_pend_q, clear_pend_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    clear_q, clear_d;
    logic                    valid_q, valid_d;
    logic [IDX_W-1:0]        src_q, src_d;
    logic [BITS-1:0]         bits_q, bits_d;
    logic                    first_q, first_d;
    logic                    first_valid_q, first_valid_d;
    logic [IDX_W-1:0]        first_src_q, first_src_d;

    logic [SOURCES*BITS-1:0] cand;
    logic [SOURCES-1:0]      pending;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [BITS-1:0]         win_bits;

    always_comb begin
        cand = i_errors & ~seen_q;
        for (int unsigned s = 0; s < SOURCES; s++) begin
            pending[s] = |cand[s*BITS +: BITS];
        end
    end

    // Scan from the source after the last grant, wrapping, so every pending source gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= SOURCES; k++) begin
            if (!win_found && pending[(32'(rr_q) + k) % SOURCES]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((32'(rr_q) + k) % SOURCES);
            end
        end
        win_bits = '0;
        for (int unsigned s = 0; s < SOURCES; s++) begin
            if (IDX_W'(s) == win_idx) begin
                win_bits = cand[s*BITS +: BITS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        seen_d        = seen_q;
        rr_d          = rr_q;
        clear_pend_d  = clear_pend_q;
        cnt_d         = cnt_q;
        clear_d       = clear_q;
        valid_d       = valid_q;
        src_d         = src_q;
        bits_d        = bits_q;
        first_d       = first_q;
        first_valid_d = first_valid_q;
        first_src_d   = first_src_q;

        unique case (state_q)
            StIdle: begin
                if (i_clear || clear_pend_q) begin
                    state_d       = StClear;
                    seen_d        = '0;
                    first_valid_d = 1'b0;
                    first_src_d   = '0;
                    rr_d          = RR_RST;
                    clear_pend_d  = 1'b0;
                    cnt_d         = CNT_W'(CLEAR_CYCLES - 1);
                    clear_d       = 1'b1;
                end else if (win_found) begin
                    state_d = StReport;
                    valid_d = 1'b1;
                    src_d   = win_idx;
                    bits_d  = win_bits;
                    rr_d    = win_idx;
                    if (!first_valid_q) begin
                        first_d       = 1'b1;
                        first_valid_d = 1'b1;
                        first_src_d   = win_idx;
                    end
                end
            end
            StReport: begin
                // A clear arriving mid-report waits until the report is accepted.
                if (i_clear) begin
                    clear_pend_d = 1'b1;
                end
                if (i_rpt_ready) begin
                    for (int unsigned s = 0; s < SOURCES; s++) begin
                        if (IDX_W'(s) == src_q) begin
                            seen_d[s*BITS +: BITS] = seen_q[s*BITS +: BITS] | bits_q;
                        end
                    end
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (cnt_q == '0) begin
                    clear_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            seen_q        <= '0;
            rr_q          <= RR_RST;
            clear_pend_q  <= 1'b0;
            cnt_q         <= '0;
            clear_q       <= 1'b0;
            valid_q       <= 1'b0;
            src_q         <= '0;
            bits_q        <= '0;
            first_q       <= 1'b0;
            first_valid_q <= 1'b0;
            first_src_q   <= '0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            rr_q          <= rr_d;
            clear_pend_q  <= clear_pend_d;
            cnt_q         <= cnt_d;
            clear_q       <= clear_d;
            valid_q       <= valid_d;
            src_q         <= src_d;
            bits_q        <= bits_d;
            first_q       <= first_d;
            first_valid_q <= first_valid_d;
            first_src_q   <= first_src_d;
        end
    end

    assign o_clear       = clear_q;
    assign o_rpt_valid   = valid_q;
    assign o_rpt_src     = src_q;
    assign o_rpt_bits    = bits_q;
    assign o_rpt_first   = first_q;
    assign o_first_valid = first_valid_q;
    assign o_first_src   = first_src_q;

endmodule

// File: tb/tb_errors_scheduler.sv
// Bench for errors_scheduler: table of single-epoch vectors plus hand-written corner sequences,
// with every accepted report checked against a queue of expected reports.
module tb_errors_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_errors;
    logic        i_clear;
    logic        o_clear;
    logic        o_rpt_valid;
    logic        i_rpt_ready;
    logic [1:0]  o_rpt_src;
    logic [7:0]  o_rpt_bits;
    logic        o_rpt_first;
    logic        o_first_valid;
    logic [1:0]  o_first_src;

    errors_scheduler #(
        .SOURCES      (4),
        .BITS         (8),
        .CLEAR_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_errors      (i_errors),
        .i_clear       (i_clear),
        .o_clear       (o_clear),
        .o_rpt_valid   (o_rpt_valid),
        .i_rpt_ready   (i_rpt_ready),
        .o_rpt_src     (o_rpt_src),
        .o_rpt_bits    (o_rpt_bits),
        .o_rpt_first   (o_rpt_first),
        .o_first_valid (o_first_valid),
        .o_first_src   (o_first_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] bits;
        logic       first;
    } rpt_t;

    // Report i of a vector sits in srcs[i*2 +: 2] / bits[i*8 +: 8]; only report 0 is first.
    typedef struct {
        logic [31:0] errs;
        int          n;
        logic [7:0]  srcs;
        logic [31:0] bits;
    } vec_t;

    rpt_t exp_q[$];
    rpt_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {o_clear, o_rpt_valid, o_rpt_src, o_rpt_bits, o_rpt_first, o_first_valid,
                o_first_src};
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_rpt_valid && i_rpt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_report: got src %0d bits %0h first %0b expected none",
                         o_rpt_src, o_rpt_bits, o_rpt_first);
            end else begin
                mon_e = exp_q.pop_front();
                check("report", {o_rpt_src, o_rpt_bits, o_rpt_first}, mon_e);
            end
        end
    end

    task automatic wait_empty(input string name, input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string name, input int bound);
        int c = 0;
        while (!o_rpt_valid && c < bound) begin
            @(negedge clk);
            c++;
        end
        check(name, o_rpt_valid, 1);
    endtask

    task automatic do_clear();
        int c = 0;
        @(posedge clk);
        #1 i_clear = 1'b1;
        @(posedge clk);
        #1 i_clear = 1'b0;
        while (o_clear && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("clear_done", o_clear, 0);
    endtask

    vec_t vecs[5];
    rpt_t r;
    int   cyc;
    int   nclr;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{errs: 32'h0020_0000, n: 1, srcs: 8'h02, bits: 32'h0000_0020};
        vecs[1] = '{errs: 32'h8100_4201, n: 3, srcs: 8'h34, bits: 32'h0081_4201};
        vecs[2] = '{errs: 32'hFF01_0203, n: 4, srcs: 8'hE4, bits: 32'hFF01_0203};
        vecs[3] = '{errs: 32'h1000_0000, n: 1, srcs: 8'h03, bits: 32'h0000_0010};
        vecs[4] = '{errs: 32'h0080_0400, n: 2, srcs: 8'h09, bits: 32'h0000_8004};

        rst_n       = 1'b0;
        i_errors    = '0;
        i_clear     = 1'b0;
        i_rpt_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 0);

        // Table: each vector runs in a fresh epoch with ready held high.
        for (int v = 0; v < 5; v++) begin
            i_errors = '0;
            do_clear();
            for (int i = 0; i < vecs[v].n; i++) begin
                r.src   = vecs[v].srcs[i*2 +: 2];
                r.bits  = vecs[v].bits[i*8 +: 8];
                r.first = (i == 0);
                exp_q.push_back(r);
            end
            @(posedge clk);
            #1 i_errors = vecs[v].errs;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 50) begin
                @(negedge clk);
                #1;
                cyc++;
                if (cyc == 1) check("latency_not_yet", o_rpt_valid, 0);
            end
            check("report_cadence", cyc, 2 * vecs[v].n);
            check("first_tag", {o_first_valid, o_first_src}, {1'b1, vecs[v].srcs[1:0]});
            repeat (4) @(negedge clk);
        end

        // Backpressure: presented report holds while a new bit arrives on the same source.
        i_errors = '0;
        do_clear();
        i_rpt_ready = 1'b0;
        @(posedge clk);
        #1 i_errors = 32'h0000_0100;
        wait_valid("bp_valid", 10);
        @(posedge clk);
        #1 i_errors = 32'h0000_0900;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable", {o_rpt_valid, o_rpt_src, o_rpt_bits, o_rpt_first},
                  {1'b1, 2'd1, 8'h01, 1'b1});
        end
        exp_q.push_back('{src: 2'd1, bits: 8'h01, first: 1'b1});
        exp_q.push_back('{src: 2'd1, bits: 8'h08, first: 1'b0});
        @(posedge clk);
        #1 i_rpt_ready = 1'b1;
        wait_empty("bp_drain", 20);
        repeat (3) @(negedge clk);

        // Clear during a stalled report; the held level re-reports in the new epoch.
        i_rpt_ready = 1'b0;
        do_clear();
        wait_valid("cr_valid", 10);
        @(posedge clk);
        #1 i_clear = 1'b1;
        @(posedge clk);
        #1 i_clear = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("cr_held", {o_rpt_valid, o_clear, o_rpt_bits}, {1'b1, 1'b0, 8'h09});
        end
        exp_q.push_back('{src: 2'd1, bits: 8'h09, first: 1'b1});
        @(posedge clk);
        #1 i_rpt_ready = 1'b1;
        cyc = 0;
        while (!o_clear && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("cr_clear_rise", o_clear, 1);
        check("cr_first_done", exp_q.size(), 0);
        exp_q.push_back('{src: 2'd1, bits: 8'h09, first: 1'b1});
        nclr = 0;
        while (o_clear && nclr < 20) begin
            nclr++;
            @(negedge clk);
        end
        check("cr_clear_len", nclr, 4);
        check("cr_first_cleared", o_first_valid, 0);
        wait_empty("cr_rereport", 20);

        // Fairness: sources 0 and 3 gain a new bit every cycle.
        i_errors = '0;
        do_clear();
        exp_q.push_back('{src: 2'd0, bits: 8'h01, first: 1'b1});
        exp_q.push_back('{src: 2'd3, bits: 8'h07, first: 1'b0});
        exp_q.push_back('{src: 2'd0, bits: 8'h1E, first: 1'b0});
        exp_q.push_back('{src: 2'd3, bits: 8'h78, first: 1'b0});
        exp_q.push_back('{src: 2'd0, bits: 8'hE0, first: 1'b0});
        exp_q.push_back('{src: 2'd3, bits: 8'h80, first: 1'b0});
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            i_errors[k]      = 1'b1;
            i_errors[24 + k] = 1'b1;
        end
        wait_empty("fair_drain", 30);
        repeat (3) @(negedge clk);

        // Asynchronous reset while a report is stalled.
        i_errors = '0;
        do_clear();
        i_rpt_ready = 1'b0;
        @(posedge clk);
        #1 i_errors = 32'h0002_0000;
        wait_valid("rst_valid", 10);
        #2 rst_n = 1'b0;
        #1 check("rst_async_report", all_outs(), 0);
        i_errors = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while the clear pulse is high.
        @(posedge clk);
        #1 i_clear = 1'b1;
        @(posedge clk);
        #1 i_clear = 1'b0;
        @(negedge clk);
        check("rst_clear_high", o_clear, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_clear", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back('{src: 2'd0, bits: 8'h01, first: 1'b1});
        exp_q.push_back('{src: 2'd2, bits: 8'h02, first: 1'b0});
        i_rpt_ready = 1'b1;
        @(posedge clk);
        #1 i_errors = 32'h0002_0001;
        wait_empty("rst_tie", 20);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
